nmi_apb_bridge: RTL
===================

Name: nmi_apb_bridge

Overview:
- Responder on the native memory interface (NMI: valid/addr/wdata/wstrb -> rdata/ready).
- Initiator of an APB3/APB4 transfer on the peripheral side.
- Sits between the bus's APB-window NMI port and the APB peripheral cluster.
- Converts each NMI request into exactly one APB SETUP/ACCESS transfer, bounds slave stalls with a timeout, and returns a sticky error status.

Parameters:
- ADDR_WIDTH, 16: APB address width; forwarded from nmi_addr_i[ADDR_WIDTH-1:0].
- TIMEOUT_CYC, 256: maximum ACCESS cycles without pready before abort; 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on timeout or pslverr.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- nmi_valid_i  in  1  request valid; held by the initiator until nmi_ready_o
- nmi_addr_i  in  32  byte address
- nmi_wdata_i  in  32  write data
- nmi_wstrb_i  in  4  byte strobes; all-zero means read
- nmi_rdata_o  out  32  read data, valid only while nmi_ready_o=1
- nmi_ready_o  out  1  single-cycle completion pulse
- paddr_o  out  ADDR_WIDTH  APB address
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB write
- pwdata_o  out  32  APB write data
- pstrb_o  out  4  APB write strobes
- prdata_i  in  32  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error
- err_clr_i  in  1  clears err_o and err_code_o
- err_o  out  1  sticky error flag
- err_code_o  out  2  last error: 01 = pslverr, 10 = timeout

Behaviour:
- Reset (asynchronous, immediate): FSM=IDLE; every output is 0; timeout counter is 0; latched request fields are 0. Reset mid-transfer drops psel/penable at once, and no nmi_ready pulse follows.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If nmi_valid_i=1, latch addr/wdata/wstrb and go to SETUP.
  - Set pwrite = |wstrb and pstrb = wstrb; on a read, pstrb=0.
- SETUP (one cycle): psel=1, penable=0, with paddr/pwrite/pwdata/pstrb driven from the latched registers. Next state is ACCESS.
- ACCESS:
  - psel=1, penable=1; APB signals stay stable until exit.
  - If pready_i=1: capture rdata (prdata_i for a read without pslverr, otherwise ERR_RDATA; writes return 0) and capture the error; go to RESP.
  - If pready_i=0: increment the counter. When the counter equals TIMEOUT_CYC-1 and pready is still 0 (TIMEOUT_CYC != 0), abort: deassert psel/penable, set rdata=ERR_RDATA and error=timeout, and go to RESP. The counter clears on ACCESS exit.
- RESP (one cycle): nmi_ready_o=1 and nmi_rdata_o is valid; psel=0, penable=0. Next state is IDLE.
- nmi_rdata_o returns to 0 outside RESP.
- Latency: valid sampled at cycle 0 -> SETUP at cycle 1 -> ACCESS at cycle 2 -> (pready at cycle 2) -> ready pulse at cycle 3. Each wait state adds 1 cycle.
- Back-to-back requests: after RESP the FSM returns to IDLE for at least one cycle, so a valid still high in the RESP cycle is never re-accepted. There is one APB transfer per NMI request.
- Valid dropped mid-transfer (protocol violation): the APB transfer still completes and the ready pulse is still issued; no state corruption.
- Error status:
  - err_o sets on pslverr_i&pready_i in ACCESS, or on timeout. err_code_o records the latest error.
  - err_clr_i clears both.
  - If set and clear coincide in the same cycle, set wins.
- Address bits above ADDR_WIDTH are ignored (no decode error).

Test Plan:
- Read with zero wait: addr=0x0000_1004, wstrb=0, pready=1 in the first ACCESS cycle, prdata=0x1234_5678 -> paddr=0x1004, pwrite=0; nmi_ready at cycle 3 with rdata=0x1234_5678; err_o=0.
- Write with 3 wait states: wdata=0xA5A5_0001, wstrb=4'b0011 -> pwrite=1, pstrb=0011, psel/penable stable for 4 ACCESS cycles; ready at cycle 6; rdata=0.
- Timeout with TIMEOUT_CYC=8 and pready held 0 -> psel drops after 8 ACCESS cycles; ready pulse with rdata=0xDEAD_BEEF; err_o=1, err_code=10. Then assert err_clr for 1 cycle -> err_o=0, err_code=00.
- pslverr read: pready=1, pslverr=1, prdata=0x0 -> rdata=0xDEAD_BEEF, err_code=01. With err_clr asserted in that same completion cycle, err_o stays 1.
- Back-to-back reads with valid held through RESP then reasserted -> exactly two SETUP phases and two ready pulses, with at least one IDLE cycle between them.
- Assert rst_i during ACCESS -> psel/penable/nmi_ready are 0 in the same cycle. After release, a fresh read completes normally with 3-cycle latency.

Source files
------------

// File: rtl/nmi_apb_bridge.sv
// nmi_apb_bridge: NMI responder that turns each request into exactly one
// APB SETUP/ACCESS transfer. Slave stalls are bounded by a timeout. The
// latest error (pslverr or timeout) is held in a sticky status register.
`timescale 1ns/1ps
module nmi_apb_bridge #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  nmi_valid_i,
    input  logic [31:0]           nmi_addr_i,
    input  logic [31:0]           nmi_wdata_i,
    input  logic [3:0]            nmi_wstrb_i,
    output logic [31:0]           nmi_rdata_o,
    output logic                  nmi_ready_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [31:0]           pwdata_o,
    output logic [3:0]            pstrb_o,
    input  logic [31:0]           prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i,
    input  logic                  err_clr_i,
    output logic                  err_o,
    output logic [1:0]            err_code_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [1:0] CODE_SLVERR  = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT = 2'b10;

    // The counter only has to reach TIMEOUT_CYC-1.
    localparam int unsigned      CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit               TO_EN    = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    logic [1:0]            state_r;
    logic [1:0]            state_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [ADDR_WIDTH-1:0] paddr_r;
    logic [31:0]           pwdata_r;
    logic [3:0]            pstrb_r;
    logic                  pwrite_r;
    logic                  psel_r;
    logic                  penable_r;
    logic                  ready_r;
    logic [31:0]           rdata_r;
    logic                  err_r;
    logic [1:0]            err_code_r;
    logic                  timeout_s;
    logic                  err_set_s;
    logic [1:0]            err_code_set_s;
    logic [31:0]           resp_data_s;

    // Address bits above the APB window are deliberately discarded.
    generate
        if (ADDR_WIDTH < 32) begin : g_addr_unused
            logic unused_addr_s;
            assign unused_addr_s = ^nmi_addr_i[31:ADDR_WIDTH];
        end
    endgenerate

    // Next-state decode; pready takes priority over a coincident timeout.
    always_comb begin
        state_s   = state_r;
        timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (nmi_valid_i) begin
                    state_s = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready_i) begin
                    state_s = ST_RESP;
                end else if (TO_EN && (cnt_r == CNT_LAST)) begin
                    timeout_s = 1'b1;
                    state_s   = ST_RESP;
                end else begin
                    state_s = ST_ACCESS;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Response data and error classification for the completing ACCESS cycle.
    always_comb begin
        err_set_s      = timeout_s || ((state_r == ST_ACCESS) && pready_i && pslverr_i);
        err_code_set_s = CODE_SLVERR;
        resp_data_s    = 32'h0000_0000;
        if (timeout_s) begin
            err_code_set_s = CODE_TIMEOUT;
            resp_data_s    = ERR_RDATA;
        end else if (pwrite_r) begin
            resp_data_s = 32'h0000_0000;
        end else if (pslverr_i) begin
            resp_data_s = ERR_RDATA;
        end else begin
            resp_data_s = prdata_i;
        end
    end

    // FSM, request latch, APB drive, stall counter and NMI response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            paddr_r   <= '0;
            pwdata_r  <= 32'h0000_0000;
            pstrb_r   <= 4'b0000;
            pwrite_r  <= 1'b0;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            ready_r   <= 1'b0;
            rdata_r   <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_IDLE: begin
                    ready_r <= 1'b0;
                    rdata_r <= 32'h0000_0000;
                    cnt_r   <= '0;
                    if (nmi_valid_i) begin
                        paddr_r   <= nmi_addr_i[ADDR_WIDTH-1:0];
                        pwdata_r  <= nmi_wdata_i;
                        pstrb_r   <= nmi_wstrb_i;
                        pwrite_r  <= |nmi_wstrb_i;
                        psel_r    <= 1'b1;
                        penable_r <= 1'b0;
                    end else begin
                        psel_r    <= 1'b0;
                        penable_r <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    penable_r <= 1'b1;
                end
                ST_ACCESS: begin
                    if (state_s == ST_RESP) begin
                        psel_r    <= 1'b0;
                        penable_r <= 1'b0;
                        ready_r   <= 1'b1;
                        rdata_r   <= resp_data_s;
                        cnt_r     <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    ready_r <= 1'b0;
                    rdata_r <= 32'h0000_0000;
                end
                default: begin
                    psel_r    <= 1'b0;
                    penable_r <= 1'b0;
                    ready_r   <= 1'b0;
                    rdata_r   <= 32'h0000_0000;
                    cnt_r     <= '0;
                end
            endcase
        end
    end

    // Sticky error status; a new error wins over a coincident clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_r      <= 1'b0;
            err_code_r <= 2'b00;
        end else if (err_set_s) begin
            err_r      <= 1'b1;
            err_code_r <= err_code_set_s;
        end else if (err_clr_i) begin
            err_r      <= 1'b0;
            err_code_r <= 2'b00;
        end else begin
            err_r      <= err_r;
            err_code_r <= err_code_r;
        end
    end

    assign nmi_rdata_o = rdata_r;
    assign nmi_ready_o = ready_r;
    assign paddr_o     = paddr_r;
    assign psel_o      = psel_r;
    assign penable_o   = penable_r;
    assign pwrite_o    = pwrite_r;
    assign pwdata_o    = pwdata_r;
    assign pstrb_o     = pstrb_r;
    assign err_o       = err_r;
    assign err_code_o  = err_code_r;

endmodule
